// File: rtl/egress_pkt_arbiter.sv
// Packet-granular weighted round-robin arbiter merging two 256b AXI4-Stream sources onto one registered egress.
// Optional per-source packet counters are built only when EGRESS_ARB_PKT_CNT_EN is defined.
module egress_pkt_arbiter #(
    parameter int unsigned QUANTUM = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             s0_tvalid,
    output logic             s0_tready,
    input  logic [255:0]     s0_tdata,
    input  logic [31:0]      s0_tkeep,
    input  logic             s0_tlast,
    input  logic [11:0]      s0_tuser,
    input  logic [2:0]       s0_tid,
    input  logic             s1_tvalid,
    output logic             s1_tready,
    input  logic [255:0]     s1_tdata,
    input  logic [31:0]      s1_tkeep,
    input  logic             s1_tlast,
    input  logic [11:0]      s1_tuser,
    input  logic [2:0]       s1_tid,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [255:0]     m_tdata,
    output logic [31:0]      m_tkeep,
    output logic             m_tlast,
    output logic [11:0]      m_tuser,
    output logic [2:0]       m_tid,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);
    localparam int unsigned BURST_W = $clog2(QUANTUM + 1);
    localparam logic [BURST_W-1:0] QUANTUM_C = BURST_W'(QUANTUM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic                last_owner_r;
    logic                next_last_owner_s;
    logic [BURST_W-1:0]  burst_cnt_r;
    logic [BURST_W-1:0]  next_burst_cnt_s;
    logic                out_ready_s;
    logic                keep_owner_s;
    logic                grant_s;
    logic                acc0_s;
    logic                acc1_s;
    logic                load_s;
    logic [255:0]        sel_data_s;
    logic [31:0]         sel_keep_s;
    logic                sel_last_s;
    logic [11:0]         sel_user_s;
    logic [2:0]          sel_id_s;

    // Source handshakes and owner selection; a zero burst count means no run is in
    // progress, so a tie goes away from last_owner (source 0 after reset).
    always_comb begin
        out_ready_s  = ~m_tvalid | m_tready;
        s0_tready    = (state_r == BUSY0) & out_ready_s;
        s1_tready    = (state_r == BUSY1) & out_ready_s;
        acc0_s       = s0_tvalid & s0_tready;
        acc1_s       = s1_tvalid & s1_tready;
        load_s       = acc0_s | acc1_s;
        keep_owner_s = (burst_cnt_r != {BURST_W{1'b0}}) && (burst_cnt_r < QUANTUM_C);
        if (s0_tvalid && s1_tvalid) begin
            grant_s = keep_owner_s ? last_owner_r : ~last_owner_r;
        end else if (s0_tvalid) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
    end

    // Next-state, burst accounting and owner history.
    always_comb begin
        next_state_s      = state_r;
        next_last_owner_s = last_owner_r;
        next_burst_cnt_s  = burst_cnt_r;
        case (state_r)
            IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    next_state_s = grant_s ? BUSY1 : BUSY0;
                    if (grant_s == last_owner_r) begin
                        if (burst_cnt_r < QUANTUM_C) begin
                            next_burst_cnt_s = burst_cnt_r + BURST_W'(1);
                        end else begin
                            next_burst_cnt_s = burst_cnt_r;
                        end
                    end else begin
                        next_burst_cnt_s  = BURST_W'(1);
                        next_last_owner_s = grant_s;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY0: begin
                if (acc0_s && s0_tlast) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = BUSY0;
                end
            end
            BUSY1: begin
                if (acc1_s && s1_tlast) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = BUSY1;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Payload mux from whichever source is handing over a beat.
    always_comb begin
        if (acc1_s) begin
            sel_data_s = s1_tdata;
            sel_keep_s = s1_tkeep;
            sel_last_s = s1_tlast;
            sel_user_s = s1_tuser;
            sel_id_s   = s1_tid;
        end else begin
            sel_data_s = s0_tdata;
            sel_keep_s = s0_tkeep;
            sel_last_s = s0_tlast;
            sel_user_s = s0_tuser;
            sel_id_s   = s0_tid;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r      <= IDLE;
            last_owner_r <= 1'b1;
            burst_cnt_r  <= {BURST_W{1'b0}};
        end else begin
            state_r      <= next_state_s;
            last_owner_r <= next_last_owner_s;
            burst_cnt_r  <= next_burst_cnt_s;
        end
    end

    // Egress register stage; payload only changes when a new beat is loaded.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            m_tvalid <= 1'b0;
            m_tdata  <= 256'd0;
            m_tkeep  <= 32'd0;
            m_tlast  <= 1'b0;
            m_tuser  <= 12'd0;
            m_tid    <= 3'd0;
        end else if (load_s) begin
            m_tvalid <= 1'b1;
            m_tdata  <= sel_data_s;
            m_tkeep  <= sel_keep_s;
            m_tlast  <= sel_last_s;
            m_tuser  <= sel_user_s;
            m_tid    <= sel_id_s;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

`ifdef EGRESS_ARB_PKT_CNT_EN
    // Per-source packet counters, wrapping at 2^CNT_W.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pkt_cnt0 <= {CNT_W{1'b0}};
            pkt_cnt1 <= {CNT_W{1'b0}};
        end else begin
            if (acc0_s && s0_tlast) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            end
            if (acc1_s && s1_tlast) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            end
        end
    end
`else
    assign pkt_cnt0 = {CNT_W{1'b0}};
    assign pkt_cnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_egress_pkt_arbiter.sv
// Self-checking bench for egress_pkt_arbiter: cycle model of the arbitration rules plus directed scenarios.
`timescale 1ns/1ps
module tb_egress_pkt_arbiter;
    localparam int QUANTUM = 4;
    localparam int CNT_W   = 4;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic [11:0]  user;
        logic [2:0]   id;
        bit           hole;
    } beat_t;

    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    logic sv[2];
    logic [255:0] sd[2];
    logic [31:0] sk[2];
    logic sl[2];
    logic [11:0] su[2];
    logic [2:0] si[2];
    logic s0_tready, s1_tready, m_tvalid, m_tready, m_tlast;
    logic [255:0] m_tdata;
    logic [31:0] m_tkeep;
    logic [11:0] m_tuser;
    logic [2:0] m_tid;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

    logic q1_v;
    logic q1_s0_tready, q1_s1_tready, q1_mv, q1_mlast;
    logic [255:0] q1_mdata;
    logic [31:0] q1_mkeep;
    logic [11:0] q1_muser;
    logic [2:0] q1_mid;
    logic [CNT_W-1:0] q1_cnt0, q1_cnt1;

    beat_t sq[2][$];
    int pops[2];
    logic fire[2];
    int out_src[$];
    int out_cyc[$];
    int q1_src[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    egress_pkt_arbiter #(.QUANTUM(QUANTUM), .CNT_W(CNT_W)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s0_tvalid(sv[0]), .s0_tready(s0_tready), .s0_tdata(sd[0]), .s0_tkeep(sk[0]),
        .s0_tlast(sl[0]), .s0_tuser(su[0]), .s0_tid(si[0]),
        .s1_tvalid(sv[1]), .s1_tready(s1_tready), .s1_tdata(sd[1]), .s1_tkeep(sk[1]),
        .s1_tlast(sl[1]), .s1_tuser(su[1]), .s1_tid(si[1]),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
        .m_tlast(m_tlast), .m_tuser(m_tuser), .m_tid(m_tid),
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
    );

    egress_pkt_arbiter #(.QUANTUM(1), .CNT_W(CNT_W)) dut_q1 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s0_tvalid(q1_v), .s0_tready(q1_s0_tready), .s0_tdata(256'd0), .s0_tkeep(32'hFFFF_FFFF),
        .s0_tlast(1'b1), .s0_tuser(12'd0), .s0_tid(3'd0),
        .s1_tvalid(q1_v), .s1_tready(q1_s1_tready), .s1_tdata(256'd1), .s1_tkeep(32'hFFFF_FFFF),
        .s1_tlast(1'b1), .s1_tuser(12'd1), .s1_tid(3'd1),
        .m_tvalid(q1_mv), .m_tready(1'b1), .m_tdata(q1_mdata), .m_tkeep(q1_mkeep),
        .m_tlast(q1_mlast), .m_tuser(q1_muser), .m_tid(q1_mid),
        .pkt_cnt0(q1_cnt0), .pkt_cnt1(q1_cnt1)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic beat_t make_beat(input int src, input int pkt, input int b, input int nb);
        beat_t t;
        logic [31:0] tag;
        tag    = {8'(src), 8'(pkt), 8'(b), 8'hA5};
        t.data = {8{tag}};
        t.last = (b == nb - 1);
        t.keep = t.last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        t.user = 12'(src * 256 + pkt * 16 + b);
        t.id   = 3'(pkt + src);
        t.hole = 1'b0;
        return t;
    endfunction

    // Pushes one packet; 'hole_at' inserts hole_len idle cycles before that beat.
    task automatic push_pkt(input int src, input int pkt, input int nb, input int hole_at, input int hole_len);
        beat_t h;
        h = make_beat(src, pkt, 0, 1);
        h.hole = 1'b1;
        for (int b = 0; b < nb; b++) begin
            if (b == hole_at) begin
                for (int k = 0; k < hole_len; k++) sq[src].push_back(h);
            end
            sq[src].push_back(make_beat(src, pkt, b, nb));
        end
    endtask

    // Source drivers: advance on a handshake seen in the previous cycle.
    initial begin
        for (int s = 0; s < 2; s++) begin
            sv[s] = 1'b0; sd[s] = 256'd0; sk[s] = 32'd0; sl[s] = 1'b0; su[s] = 12'd0; si[s] = 3'd0;
            pops[s] = 0; fire[s] = 1'b0;
        end
        forever begin
            @(negedge ap_clk);
            fire[0] = sv[0] && s0_tready;
            fire[1] = sv[1] && s1_tready;
            @(posedge ap_clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (fire[s] && sq[s].size() > 0) begin
                    void'(sq[s].pop_front());
                    pops[s]++;
                end
                if (sq[s].size() > 0 && sq[s][0].hole) begin
                    sv[s] = 1'b0;
                    void'(sq[s].pop_front());
                end else if (sq[s].size() > 0) begin
                    sv[s] = 1'b1;
                    sd[s] = sq[s][0].data;
                    sk[s] = sq[s][0].keep;
                    sl[s] = sq[s][0].last;
                    su[s] = sq[s][0].user;
                    si[s] = sq[s][0].id;
                end else begin
                    sv[s] = 1'b0;
                end
            end
        end
    end

    // Reference model: packet owner, tie history and the single output register.
    int mdl_owner, mdl_lastown, mdl_burst;
    logic mdl_mvalid, mdl_tlast;
    logic [255:0] mdl_data;
    logic [31:0] mdl_keep;
    logic [11:0] mdl_user;
    logic [2:0] mdl_id;
    logic [CNT_W-1:0] mdl_cnt[2];

    function automatic int choose(input logic v0, input logic v1, input int lastown, input int burst);
        if (v0 && v1) return (burst > 0 && burst < QUANTUM) ? lastown : 1 - lastown;
        else if (v0) return 0;
        else return 1;
    endfunction

    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mdl_owner <= -1; mdl_lastown <= 1; mdl_burst <= 0; mdl_mvalid <= 1'b0;
            mdl_data <= 256'd0; mdl_keep <= 32'd0; mdl_tlast <= 1'b0; mdl_user <= 12'd0; mdl_id <= 3'd0;
            mdl_cnt[0] <= '0; mdl_cnt[1] <= '0;
        end else if (mdl_owner < 0) begin
            if (sv[0] || sv[1]) begin
                mdl_owner   <= choose(sv[0], sv[1], mdl_lastown, mdl_burst);
                mdl_lastown <= choose(sv[0], sv[1], mdl_lastown, mdl_burst);
                mdl_burst   <= (choose(sv[0], sv[1], mdl_lastown, mdl_burst) == mdl_lastown)
                               ? ((mdl_burst < QUANTUM) ? mdl_burst + 1 : QUANTUM) : 1;
            end
            if (m_tready) mdl_mvalid <= 1'b0;
        end else if (sv[mdl_owner] && (!mdl_mvalid || m_tready)) begin
            mdl_mvalid <= 1'b1;
            mdl_data <= sd[mdl_owner]; mdl_keep <= sk[mdl_owner]; mdl_tlast <= sl[mdl_owner];
            mdl_user <= su[mdl_owner]; mdl_id <= si[mdl_owner];
            if (sl[mdl_owner]) begin
                mdl_owner <= -1;
                mdl_cnt[mdl_owner] <= mdl_cnt[mdl_owner] + CNT_W'(1);
            end
        end else if (m_tready) begin
            mdl_mvalid <= 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge ap_clk) begin
        check("tready", 256'({s0_tready, s1_tready}),
              256'({(mdl_owner == 0) && (!mdl_mvalid || m_tready), (mdl_owner == 1) && (!mdl_mvalid || m_tready)}));
        check("m_tvalid", 256'(m_tvalid), 256'(mdl_mvalid));
        check("m_tdata", m_tdata, mdl_data);
        check("m_side", 256'({m_tkeep, m_tlast, m_tuser, m_tid}), 256'({mdl_keep, mdl_tlast, mdl_user, mdl_id}));
`ifdef EGRESS_ARB_PKT_CNT_EN
        check("pkt_cnt", 256'({pkt_cnt0, pkt_cnt1}), 256'({mdl_cnt[0], mdl_cnt[1]}));
`else
        check("pkt_cnt", 256'({pkt_cnt0, pkt_cnt1}), 256'd0);
`endif
        if (ap_rst_n && m_tvalid && m_tready) begin
            out_src.push_back(int'(m_tdata[255:248]));
            out_cyc.push_back(cyc);
        end
        if (ap_rst_n && q1_mv) q1_src.push_back(int'(q1_mid));
    end

    task automatic wait_drain(input string name, input int max_cyc);
        int n = 0;
        while ((sq[0].size() > 0 || sq[1].size() > 0 || m_tvalid) && n < max_cyc) begin
            @(posedge ap_clk); #2; n++;
        end
        check({name, "_timeout"}, 256'(n < max_cyc), 256'(1));
        repeat (2) begin @(posedge ap_clk); #2; end
    endtask

    task automatic wait_pops(input string name, input int s, input int target);
        int n = 0;
        while (pops[s] < target && n < 100) begin @(posedge ap_clk); #2; n++; end
        check({name, "_timeout"}, 256'(n < 100), 256'(1));
    endtask

    task automatic pulse_reset();
        @(posedge ap_clk); #3;
        ap_rst_n = 1'b0;
        sq[0].delete(); sq[1].delete();
        sv[0] = 1'b0; sv[1] = 1'b0;
        #1;
        check("rst_m_tvalid", 256'(m_tvalid), 256'(0));
        check("rst_treadys", 256'({s0_tready, s1_tready}), 256'(0));
        repeat (2) @(posedge ap_clk);
        #2 ap_rst_n = 1'b1;
    endtask

    int exp_t2[20] = '{0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1,0,0,1,1};
    int exp_t3[6]  = '{0,0,0,0,0,1};
    int base, p0, nz;

    initial begin
        m_tready = 1'b1;
        q1_v = 1'b0;
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge ap_clk);
        check("reset_m_tvalid", 256'(m_tvalid), 256'(0));
        check("reset_m_tdata", m_tdata, 256'd0);
        check("reset_treadys", 256'({s0_tready, s1_tready}), 256'(0));
        repeat (2) @(posedge ap_clk);
        #2 ap_rst_n = 1'b1;

        // Both sources saturated with 1-beat packets: quantum 4 here, quantum 1 on dut_q1.
        out_src.delete(); q1_src.delete();
        for (int k = 0; k < 10; k++) begin push_pkt(0, k, 1, -1, 0); push_pkt(1, k, 1, -1, 0); end
        q1_v = 1'b1;
        wait_drain("t2", 200);
        q1_v = 1'b0;
        check("t2_count", 256'(out_src.size()), 256'(20));
        for (int i = 0; i < 20 && i < out_src.size(); i++) check("t2_order", 256'(out_src[i]), 256'(exp_t2[i]));
        check("q1_enough", 256'(q1_src.size() >= 6), 256'(1));
        for (int i = 0; i < 6 && i < q1_src.size(); i++) check("q1_order", 256'(q1_src[i]), 256'(i % 2));

        // Single source, 3 packets x 4 beats: 12 beats spanning 13 cycles (two bubbles).
        out_src.delete(); out_cyc.delete();
        for (int k = 0; k < 3; k++) push_pkt(0, k, 4, -1, 0);
        wait_drain("t1", 100);
        check("t1_count", 256'(out_cyc.size()), 256'(12));
        if (out_cyc.size() == 12) check("t1_span", 256'(out_cyc[11] - out_cyc[0]), 256'(13));
        nz = 0;
        foreach (out_src[i]) if (out_src[i] != 0) nz++;
        check("t1_only_s0", 256'(nz), 256'(0));

        // Owner holds through a 3-cycle tvalid gap while the other source waits.
        out_src.delete();
        push_pkt(0, 7, 5, 2, 3);
        repeat (3) begin @(posedge ap_clk); #2; end
        push_pkt(1, 7, 1, -1, 0);
        wait_drain("t3", 100);
        check("t3_count", 256'(out_src.size()), 256'(6));
        for (int i = 0; i < 6 && i < out_src.size(); i++) check("t3_order", 256'(out_src[i]), 256'(exp_t3[i]));

        // Egress stall of 5 cycles mid-packet.
        out_src.delete();
        base = pops[0];
        push_pkt(0, 9, 6, -1, 0);
        wait_pops("t4_start", 0, base + 2);
        m_tready = 1'b0;
        p0 = pops[0];
        repeat (5) begin @(posedge ap_clk); #2; end
        check("t4_stall_accepts", 256'(pops[0] - p0 <= 1), 256'(1));
        m_tready = 1'b1;
        wait_drain("t4", 100);
        check("t4_count", 256'(out_src.size()), 256'(6));

        // Reset in the middle of a packet, then a tie goes to source 0.
        base = pops[0];
        push_pkt(0, 11, 6, -1, 0);
        wait_pops("t5_start", 0, base + 3);
        pulse_reset();
        out_src.delete();
        push_pkt(0, 12, 1, -1, 0);
        push_pkt(1, 12, 1, -1, 0);
        wait_drain("t5", 100);
        check("t5_count", 256'(out_src.size()), 256'(2));
        if (out_src.size() == 2) begin
            check("t5_first", 256'(out_src[0]), 256'(0));
            check("t5_second", 256'(out_src[1]), 256'(1));
        end

        // 17 packets from source 1 with 4-bit counters.
        pulse_reset();
        for (int k = 0; k < 17; k++) push_pkt(1, k, 1, -1, 0);
        wait_drain("t6", 200);
`ifdef EGRESS_ARB_PKT_CNT_EN
        check("t6_cnt1", 256'(pkt_cnt1), 256'(1));
`else
        check("t6_cnt1", 256'(pkt_cnt1), 256'(0));
`endif
        check("t6_cnt0", 256'(pkt_cnt0), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
